// File: rtl/spi_slave_word_rx_if.sv
// SPI receive link bundle: serial pins from the master plus the
// reassembled byte/word outputs and error status of the receiver.
interface spi_slave_word_rx_if;
   logic        sclk;
   logic        mosi;
   logic        ss;
   logic [7:0]  byte_data;
   logic        byte_valid;
   logic [15:0] word_data;
   logic        word_valid;
   logic        frame_err;
   logic [1:0]  err_code;
   logic        busy;

   modport slave (
      input  sclk, mosi, ss,
      output byte_data, byte_valid, word_data, word_valid,
             frame_err, err_code, busy
   );

   modport master (
      output sclk, mosi, ss,
      input  byte_data, byte_valid, word_data, word_valid,
             frame_err, err_code, busy
   );
endinterface

// File: rtl/spi_slave_word_rx.sv
// SPI mode-0 slave receiver, MSB first, oversampled on clk.
// Collects two bytes (upper then lower) into a 16-bit word, flags
// partial-byte frames and inter-byte timeouts, then resyncs to the
// upper byte.
module spi_slave_word_rx #(
   parameter int unsigned SYNC_STAGES    = 2,
   parameter int unsigned TIMEOUT_CYCLES = 100_000
) (
   input  logic                  clk,
   input  logic                  reset,
   spi_slave_word_rx_if.slave    bus
);

   localparam int unsigned TMO_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

   typedef enum logic {
      WAIT_HI = 1'b0,
      WAIT_LO = 1'b1
   } state_t;

   logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d;
   logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
   logic [SYNC_STAGES-1:0] ss_sync_q,   ss_sync_d;
   logic                   sclk_d1_q,   sclk_d1_d;
   logic                   ss_d1_q,     ss_d1_d;

   state_t                 state_q,      state_d;
   logic [2:0]             bit_cnt_q,    bit_cnt_d;
   logic [7:0]             shreg_q,      shreg_d;
   logic [7:0]             upper_q,      upper_d;
   logic [7:0]             byte_data_q,  byte_data_d;
   logic                   byte_valid_q, byte_valid_d;
   logic [15:0]            word_data_q,  word_data_d;
   logic                   word_valid_q, word_valid_d;
   logic                   frame_err_q,  frame_err_d;
   logic [1:0]             err_code_q,   err_code_d;
   logic [TMO_W-1:0]       tmo_q,        tmo_d;

   logic       sclk_s, mosi_s, ss_s;
   logic       sample, ss_fall, ss_rise, byte_done;
   logic [2:0] cnt_base;
   logic [7:0] byte_next;

   assign sclk_s = sclk_sync_q[SYNC_STAGES-1];
   assign mosi_s = mosi_sync_q[SYNC_STAGES-1];
   assign ss_s   = ss_sync_q[SYNC_STAGES-1];

   assign sample  = sclk_s & ~sclk_d1_q & ~ss_s;
   assign ss_fall = ~ss_s & ss_d1_q;
   assign ss_rise = ss_s & ~ss_d1_q;

   // Synchroniser shift chains and the edge-detect delay flops.
   always_comb begin
      sclk_sync_d = {sclk_sync_q[SYNC_STAGES-2:0], bus.sclk};
      mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], bus.mosi};
      ss_sync_d   = {ss_sync_q[SYNC_STAGES-2:0],   bus.ss};
      sclk_d1_d   = sclk_s;
      ss_d1_d     = ss_s;
   end

   // Bit shifting, byte framing, word FSM, timeout and error reporting.
   always_comb begin
      state_d      = state_q;
      bit_cnt_d    = bit_cnt_q;
      shreg_d      = shreg_q;
      upper_d      = upper_q;
      byte_data_d  = byte_data_q;
      byte_valid_d = 1'b0;
      word_data_d  = word_data_q;
      word_valid_d = 1'b0;
      frame_err_d  = 1'b0;
      err_code_d   = err_code_q;
      tmo_d        = tmo_q;

      // A frame start restarts the bit count before any same-cycle sample.
      cnt_base  = ss_fall ? 3'd0 : bit_cnt_q;
      byte_next = {shreg_q[6:0], mosi_s};
      byte_done = sample && (cnt_base == 3'd7);

      bit_cnt_d = cnt_base;
      if (sample) begin
         shreg_d   = byte_next;
         bit_cnt_d = cnt_base + 3'd1;
      end

      if (state_q == WAIT_LO) begin
         tmo_d = sample ? '0 : tmo_q + TMO_W'(1);
      end

      if (byte_done) begin
         byte_data_d  = byte_next;
         byte_valid_d = 1'b1;
      end

      unique case (state_q)
         WAIT_HI: begin
            if (byte_done) begin
               upper_d = byte_next;
               state_d = WAIT_LO;
               tmo_d   = '0;
            end
         end
         WAIT_LO: begin
            // A completing byte beats a coincident timeout terminal count.
            if (byte_done) begin
               word_data_d  = {upper_q, byte_next};
               word_valid_d = 1'b1;
               state_d      = WAIT_HI;
               tmo_d        = '0;
            end else if (tmo_q == TMO_LAST) begin
               state_d     = WAIT_HI;
               bit_cnt_d   = '0;
               frame_err_d = 1'b1;
               err_code_d  = 2'b10;
               tmo_d       = '0;
            end
         end
         default: state_d = WAIT_HI;
      endcase

      if (ss_rise && (bit_cnt_q != 3'd0)) begin
         bit_cnt_d   = '0;
         state_d     = WAIT_HI;
         frame_err_d = 1'b1;
         err_code_d  = 2'b01;
         tmo_d       = '0;
      end
   end

   // Register stage for synchronisers, FSM state and all outputs.
   always_ff @(posedge clk) begin
      if (reset) begin
         sclk_sync_q  <= '0;
         mosi_sync_q  <= '0;
         ss_sync_q    <= '1;
         sclk_d1_q    <= 1'b0;
         ss_d1_q      <= 1'b1;
         state_q      <= WAIT_HI;
         bit_cnt_q    <= '0;
         shreg_q      <= '0;
         upper_q      <= '0;
         byte_data_q  <= '0;
         byte_valid_q <= 1'b0;
         word_data_q  <= '0;
         word_valid_q <= 1'b0;
         frame_err_q  <= 1'b0;
         err_code_q   <= '0;
         tmo_q        <= '0;
      end else begin
         sclk_sync_q  <= sclk_sync_d;
         mosi_sync_q  <= mosi_sync_d;
         ss_sync_q    <= ss_sync_d;
         sclk_d1_q    <= sclk_d1_d;
         ss_d1_q      <= ss_d1_d;
         state_q      <= state_d;
         bit_cnt_q    <= bit_cnt_d;
         shreg_q      <= shreg_d;
         upper_q      <= upper_d;
         byte_data_q  <= byte_data_d;
         byte_valid_q <= byte_valid_d;
         word_data_q  <= word_data_d;
         word_valid_q <= word_valid_d;
         frame_err_q  <= frame_err_d;
         err_code_q   <= err_code_d;
         tmo_q        <= tmo_d;
      end
   end

   assign bus.byte_data  = byte_data_q;
   assign bus.byte_valid = byte_valid_q;
   assign bus.word_data  = word_data_q;
   assign bus.word_valid = word_valid_q;
   assign bus.frame_err  = frame_err_q;
   assign bus.err_code   = err_code_q;
   assign bus.busy       = ~ss_s | (state_q == WAIT_LO);

endmodule

// File: tb/tb_spi_slave_word_rx.sv
// Scoreboard bench for spi_slave_word_rx: the stimulus pushes expected
// bytes, words and error codes; a monitor pops them on each output pulse.
module tb_spi_slave_word_rx;

   logic clk;
   logic reset;
   int   n_cmp;
   int   n_err;

   logic [7:0]  exp_byte[$];
   logic [15:0] exp_word[$];
   logic [1:0]  exp_err[$];

   spi_slave_word_rx_if bus ();

   spi_slave_word_rx #(
      .SYNC_STAGES    (2),
      .TIMEOUT_CYCLES (64)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic spi_bit(input logic b);
      bus.mosi = b;
      tick(4);
      bus.sclk = 1'b1;
      tick(4);
      bus.sclk = 1'b0;
   endtask

   task automatic send_byte(input logic [7:0] b);
      for (int i = 7; i >= 0; i--) spi_bit(b[i]);
   endtask

   task automatic frame_byte(input logic [7:0] b);
      bus.ss = 1'b0;
      tick(4);
      send_byte(b);
      tick(4);
      bus.ss = 1'b1;
      tick(4);
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_byte_data"},  16'(bus.byte_data),  16'h0000);
      chk({tag, "_byte_valid"}, 16'(bus.byte_valid), 16'h0000);
      chk({tag, "_word_data"},  bus.word_data,       16'h0000);
      chk({tag, "_word_valid"}, 16'(bus.word_valid), 16'h0000);
      chk({tag, "_frame_err"},  16'(bus.frame_err),  16'h0000);
      chk({tag, "_err_code"},   16'(bus.err_code),   16'h0000);
      chk({tag, "_busy"},       16'(bus.busy),       16'h0000);
   endtask

   // Monitor: every output pulse must match the oldest pending expectation.
   always @(negedge clk) begin
      if (!reset) begin
         if (bus.byte_valid) begin
            if (exp_byte.size() == 0) begin
               n_cmp++; n_err++;
               $display("FAIL byte_unexpected: got %h expected none", bus.byte_data);
            end else begin
               chk("byte_data", 16'(bus.byte_data), 16'(exp_byte.pop_front()));
            end
         end
         if (bus.word_valid) begin
            if (exp_word.size() == 0) begin
               n_cmp++; n_err++;
               $display("FAIL word_unexpected: got %h expected none", bus.word_data);
            end else begin
               chk("word_data", bus.word_data, exp_word.pop_front());
            end
         end
         if (bus.frame_err) begin
            if (exp_err.size() == 0) begin
               n_cmp++; n_err++;
               $display("FAIL err_unexpected: got %h expected none", bus.err_code);
            end else begin
               chk("err_code", 16'(bus.err_code), 16'(exp_err.pop_front()));
            end
         end
      end
   end

   initial begin
      n_cmp     = 0;
      n_err     = 0;
      reset     = 1'b1;
      bus.sclk  = 1'b0;
      bus.mosi  = 1'b0;
      bus.ss    = 1'b1;
      tick(4);
      reset = 1'b0;
      tick(1);
      check_reset_outputs("rst");

      // Two framed bytes form one word.
      exp_byte.push_back(8'h12);
      exp_byte.push_back(8'h34);
      exp_word.push_back(16'h1234);
      frame_byte(8'h12);
      chk("busy_wait_lo", 16'(bus.busy), 16'h0001);
      frame_byte(8'h34);
      tick(4);

      // Back-to-back bytes in a single ss-low window.
      exp_byte.push_back(8'h27);
      exp_byte.push_back(8'h0F);
      exp_word.push_back(16'h270F);
      bus.ss = 1'b0;
      tick(4);
      send_byte(8'h27);
      send_byte(8'h0F);
      tick(4);
      bus.ss = 1'b1;
      tick(8);

      // Partial byte (5 bits) then a good word.
      exp_err.push_back(2'b01);
      bus.ss = 1'b0;
      tick(4);
      spi_bit(1'b1); spi_bit(1'b0); spi_bit(1'b1); spi_bit(1'b1); spi_bit(1'b0);
      tick(4);
      bus.ss = 1'b1;
      tick(8);
      chk("partial_err_code_hold", 16'(bus.err_code), 16'h0001);
      exp_byte.push_back(8'hAB);
      exp_byte.push_back(8'hCD);
      exp_word.push_back(16'hABCD);
      frame_byte(8'hAB);
      frame_byte(8'hCD);
      tick(4);

      // Inter-byte timeout, then a fresh word from the upper byte.
      exp_byte.push_back(8'h27);
      exp_err.push_back(2'b10);
      frame_byte(8'h27);
      tick(70);
      chk("timeout_err_code", 16'(bus.err_code), 16'h0002);
      chk("timeout_busy_idle", 16'(bus.busy), 16'h0000);
      exp_byte.push_back(8'h00);
      exp_byte.push_back(8'h01);
      exp_word.push_back(16'h0001);
      frame_byte(8'h00);
      frame_byte(8'h01);
      tick(4);
      chk("err_code_after_good", 16'(bus.err_code), 16'h0002);

      // Reset mid-operation: upper byte accepted, 3 bits into the lower.
      exp_byte.push_back(8'h55);
      frame_byte(8'h55);
      chk("busy_after_55", 16'(bus.busy), 16'h0001);
      bus.ss = 1'b0;
      tick(4);
      spi_bit(1'b1); spi_bit(1'b0); spi_bit(1'b1);
      reset = 1'b1;
      tick(1);
      reset = 1'b0;
      check_reset_outputs("midrst");
      bus.ss = 1'b1;
      tick(8);
      exp_byte.push_back(8'h12);
      exp_byte.push_back(8'h34);
      exp_word.push_back(16'h1234);
      frame_byte(8'h12);
      frame_byte(8'h34);
      tick(4);

      // sclk toggling with ss high must be ignored.
      for (int i = 0; i < 10; i++) begin
         bus.mosi = 1'b1;
         tick(4);
         bus.sclk = 1'b1;
         tick(4);
         bus.sclk = 1'b0;
         chk("ss_high_busy", 16'(bus.busy), 16'h0000);
      end
      tick(8);
      chk("ss_high_word_hold", bus.word_data, 16'h1234);

      tick(20);
      chk("byte_queue_drained", 16'(exp_byte.size()), 16'h0000);
      chk("word_queue_drained", 16'(exp_word.size()), 16'h0000);
      chk("err_queue_drained",  16'(exp_err.size()),  16'h0000);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
